// File: rtl/dmem_rom_arbiter.sv
// dmem_rom_arbiter: round-robin ROM read arbiter with streamer burst lock (DMEM_ARB_BOUNDS_CHECK_EN adds range check + sticky err).
module dmem_rom_arbiter #(
  parameter int unsigned DEPTH     = 8100,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  input  logic        lock1,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  ,output logic       err
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [31:0]   sel_addr, rd_word;
  logic          oob;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  logic          err_q, err_d;
  assign err = err_q;
`endif
  always_comb begin
    // port 1 wins when alone, when it is its turn, or while its burst lock holds
    gnt1     = !reset && req1 && (!req0 || !last_q || (lock1 && cnt_q < CW'(MAX_BURST)));
    gnt0     = !reset && req0 && !gnt1;
    sel_addr = gnt1 ? addr1 : gnt0 ? addr0 : '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    oob      = (gnt0 || gnt1) && sel_addr >= 32'(DEPTH);
    err_d    = err_q || oob;
`else
    oob      = 1'b0;
`endif
    rom_addr = oob ? '0 : sel_addr;
    rd_word  = oob ? '0 : rom_rd;
    last_d   = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_q;
    cnt_d    = (gnt1 && lock1) ? (cnt_q == CW'(MAX_BURST) ? cnt_q : cnt_q + CW'(1)) : '0;
    pend_d   = {gnt1, gnt0};
    rdata0_d = gnt0 ? rd_word : rdata0_q;
    rdata1_d = gnt1 ? rd_word : rdata1_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      cnt_q    <= '0;
      pend_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end
  assign rvalid0 = pend_q[0];
  assign rvalid1 = pend_q[1];
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
endmodule

// File: tb/tb_dmem_rom_arbiter.sv
// tb_dmem_rom_arbiter: directed vector table, reset corner cases and randomized traffic against a reference model.
module tb_dmem_rom_arbiter;
  localparam int DEPTH = 8100;
  localparam int MB    = 4;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, rom_addr, rom_rd;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  logic        err;
`endif
  int cmp_n = 0, fail_n = 0;
  int m_last, m_cnt;
  bit m_v0, m_v1, m_err;
  logic [31:0] m_d0, m_d1;

  dmem_rom_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .lock1(lock1), .rom_addr(rom_addr), .rom_rd(rom_rd)
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  assign rom_rd = rom_f(rom_addr);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_cnt = 0; m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0; m_err = 0;
  endtask

  // Called at a falling edge: drive, check, advance the model, wait for the next falling edge.
  task automatic cyc(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                     input bit l, output int w, output int dg);
    logic [31:0] ea, ed;
    bit bad;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; lock1 = l;
    #1;
    if (r0 && r1) w = (m_last == 1 && l && m_cnt < MB) ? 1 : 1 - m_last;
    else w = r0 ? 0 : r1 ? 1 : -1;
    ea = (w == 0) ? a0 : (w == 1) ? a1 : 32'd0;
    bad = 0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    bad = (w >= 0) && (ea >= DEPTH);
`endif
    if (bad) ea = '0;
    ed = bad ? 32'd0 : rom_f(ea);
    dg = gnt0 ? 0 : gnt1 ? 1 : -1;
    chk("gnt0", {31'd0, gnt0}, {31'd0, w == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, w == 1});
    chk("rom_addr", rom_addr, ea);
    chk("rvalid0", {31'd0, rvalid0}, {31'd0, m_v0});
    chk("rvalid1", {31'd0, rvalid1}, {31'd0, m_v1});
    chk("rdata0", rdata0, m_d0);
    chk("rdata1", rdata1, m_d1);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    chk("err", {31'd0, err}, {31'd0, m_err});
`endif
    m_v0 = (w == 0);
    m_v1 = (w == 1);
    if (w == 0) m_d0 = ed;
    if (w == 1) m_d1 = ed;
    m_cnt = (w == 1 && l) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 0;
    if (w >= 0) m_last = w;
    if (bad) m_err = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
    #1;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit r0; logic [31:0] a0; bit r1; logic [31:0] a1; bit l; int eg;
  } vec_t;

  initial begin
    vec_t tv[$];
    int w, dg;
    bit p0, p1, l;
    logic [31:0] q0, q1;
    tv.push_back('{1, 5, 1, 100, 0, 0});
    tv.push_back('{1, 6, 0, 0, 0, 0});
    tv.push_back('{1, 7, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, -1});
    tv.push_back('{1, 10, 1, 20, 0, 1});
    tv.push_back('{1, 11, 1, 21, 0, 0});
    tv.push_back('{1, 12, 1, 22, 0, 1});
    tv.push_back('{1, 13, 1, 23, 0, 0});
    tv.push_back('{1, 30, 1, 40, 1, 1});
    tv.push_back('{1, 30, 1, 41, 1, 1});
    tv.push_back('{1, 30, 1, 42, 1, 1});
    tv.push_back('{1, 30, 1, 43, 1, 1});
    tv.push_back('{1, 30, 1, 44, 1, 0});
    tv.push_back('{1, 31, 1, 44, 1, 1});
    tv.push_back('{1, 31, 1, 45, 0, 0});
    tv.push_back('{0, 0, 1, 46, 1, 1});
    tv.push_back('{1, 32, 0, 0, 1, 0});
    tv.push_back('{0, 0, 0, 0, 0, -1});
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();
    foreach (tv[i]) begin
      cyc(tv[i].r0, tv[i].a0, tv[i].r1, tv[i].a1, tv[i].l, w, dg);
      chk($sformatf("tv%0d_grant", i), dg, tv[i].eg);
    end
    // reset lands while a port-1 read is in flight
    cyc(0, 0, 1, 42, 0, w, dg);
    cyc(0, 0, 1, 43, 0, w, dg);
    #1 reset = 1'b1;
    #1 chk("midrst_gnt1", {31'd0, gnt1}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("midrst_rdata1", rdata1, 32'd0);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b0;
    model_reset();
    cyc(0, 0, 0, 0, 0, w, dg);
    chk("post_rst_rvalid1", {31'd0, rvalid1}, 32'd0);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    cyc(1, DEPTH, 0, 0, 0, w, dg);
    cyc(0, 0, 0, 0, 0, w, dg);
    chk("oob_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("oob_rdata0", rdata0, 32'd0);
    cyc(1, 3, 0, 0, 0, w, dg);
    cyc(0, 0, 0, 0, 0, w, dg);
    chk("oob_rdata0_ok", rdata0, rom_f(32'd3));
    chk("oob_err_sticky", {31'd0, err}, 32'd1);
`endif
    p0 = 0; p1 = 0; q0 = '0; q1 = '0;
    for (int n = 0; n < 500; n++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1; q0 = $urandom_range(0, DEPTH - 1); end
      if (!p1 && $urandom_range(0, 3) != 0) begin p1 = 1; q1 = $urandom_range(0, DEPTH - 1); end
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      if ($urandom_range(0, 30) == 0) q1 = DEPTH + $urandom_range(0, 50);
`endif
      l = $urandom_range(0, 3) != 0;
      cyc(p0, q0, p1, q1, l, w, dg);
      if (w == 0) p0 = 0;
      if (w == 1) p1 = 0;
      if (p0 && $urandom_range(0, 15) == 0) p0 = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule

// File: doc/dmem_rom_arbiter.md
# dmem_rom_arbiter

Two-port arbiter that shares the single combinational-read data ROM between the pipeline's MEM-stage load port (port 0) and the image-streaming reader (port 1). It drives the ROM address, registers the ROM read word, and returns it to the granted requester one cycle later. Round-robin selection, a bounded burst lock for the streamer and an optional address bounds check make sure neither requester starves the other.

## Interface
- `DEPTH`, 8100: ROM depth in 32-bit words; the valid word addresses are 0..DEPTH-1.
- `MAX_BURST`, 16: maximum number of consecutive locked port-1 grants before a forced yield.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  port-0 read request; held until `gnt0` is sampled high.
- `addr0`  in  32  port-0 word address; must be stable while `req0` is high.
- `gnt0`  out  1  combinational grant; the request is accepted in this cycle.
- `rvalid0`  out  1  `rdata0` is valid; a one-cycle pulse.
- `rdata0`  out  32  port-0 read data; holds its value until the next `rvalid0`.
- `req1`, `addr1`, `gnt1`, `rvalid1`, `rdata1`: same as port 0, for port 1.
- `lock1`  in  1  port 1 requests back-to-back ownership (burst).
- `rom_addr`  out  32  address to the ROM; 0 when idle.
- `rom_rd`  in  32  ROM read data, combinational from `rom_addr`.
- `err`  out  1  sticky out-of-range flag; present only with `DMEM_ARB_BOUNDS_CHECK_EN`.

## Operation
- State registers:
  - `last`: the last port granted. Reset value 1, so port 0 wins the first tie.
  - `burst_cnt`: counts 0..MAX_BURST.
  - `pend`: 2-bit one-hot, marks which port receives data next cycle.
  - Output data registers.
- Grant rules, evaluated in the same cycle; at most one grant per cycle:
  - Only one request is active: grant it.
  - Both requests are active, `last`==1, `lock1`=1 and `burst_cnt`<MAX_BURST: grant port 1 (lock hold).
  - Both requests are active otherwise: grant the port that is not `last`.
  - No request is active: no grant, `rom_addr`=0, and `last` is unchanged.
- Burst counter:
  - A port-1 grant with `lock1`=1 increments `burst_cnt`, saturating at MAX_BURST.
  - A port-0 grant, or any cycle with `lock1`=0, clears it.
  - At MAX_BURST with `req0` high, port 0 is granted for exactly one cycle, then the lock may resume.
- On a grant, `rom_addr` is the granted address and `rom_rd` is captured into the granted port's `rdata` at the clock edge. That port's `rvalid` pulses high for one cycle after the edge. The other port's `rdata` is unchanged.
- Addresses are word indices. The low 32 bits are passed unmodified in the base build.

## Timing
- Grant latency: 0 cycles; `gnt` is combinational from `req`, `lock1`, `last` and `burst_cnt`.
- Read latency: 1 cycle. Request granted in cycle N gives `rvalid`/`rdata` in cycle N+1.
- Throughput: 1 read per cycle in total across both ports.
- Back-to-back grants to the same port give consecutive `rvalid` pulses.
- Reset values:
  - `gnt0`=`gnt1`=0 while `reset` is high.
  - `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0.
  - `rom_addr`=0, `last`=1, `burst_cnt`=0, `pend`=0, `err`=0.
- Reset mid-operation:
  - An in-flight read, where `pend` is set, is discarded.
  - No `rvalid` is produced after reset deasserts.
  - Requesters re-request.
- `req` dropped before a grant: legal; the request is withdrawn with no side effects.
- `lock1` high with `req1` low: the lock is ignored and `burst_cnt` clears.

## Configuration
- `DMEM_ARB_BOUNDS_CHECK_EN` defined:
  - A granted address >= DEPTH drives `rom_addr`=0.
  - The returned data is forced to 32'h0 while the `rvalid` pulse still occurs.
  - `err` sets and stays set until reset.
- Not defined:
  - No range check; the address is passed through.
  - The `err` port is absent.

## Test plan
- Reset with `req0`=`req1`=1 -> all outputs 0. First cycle after reset: `gnt0`=1, `gnt1`=0. Next cycle: `rvalid0`=1 with `rdata0`=ROM[`addr0`].
- `req0` only, addr0=5,6,7 on consecutive cycles -> `rvalid0` high for 3 cycles with data ROM[5],ROM[6],ROM[7], each 1 cycle late.
- Both requesting continuously with `lock1`=0 -> grants alternate 0,1,0,1 and each `rvalid` matches its own address.
- Both requesting, `lock1`=1, MAX_BURST=4, starting with a port-1 grant -> 4 port-1 grants, then 1 port-0 grant, then port 1 resumes.
- Reset asserted the cycle after a port-1 grant -> `rvalid1` stays 0 and `rdata1`=0.
- With `DMEM_ARB_BOUNDS_CHECK_EN`, addr0=8100 -> `rdata0`=0, `rvalid0`=1, and `err`=1 stays set after a later valid access to addr0=3.
